// File: rtl/atm_pin_checker.sv
// ATM PIN entry checker: collects BCD digits while a card is present, compares
// against the reference PIN and locks the card out after too many failed entries.
module atm_pin_checker #(
    parameter int PIN_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    card_in,
    input  logic                    digit_valid,
    input  logic [3:0]              digit,
    input  logic                    cancel,
    input  logic [4*PIN_DIGITS-1:0] stored_pin,
    output logic                    pin_ok,
    output logic                    pin_fail,
    output logic                    locked,
    output logic [2:0]              tries_left,
    output logic [2:0]              digit_cnt
);

    localparam int EW = 4 * PIN_DIGITS;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]    MAX_TRIES_L = 3'(MAX_TRIES);
    localparam logic [2:0]    LAST_CNT    = 3'(PIN_DIGITS - 1);
    localparam logic [TW-1:0] TMO         = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CHECK   = 3'd2,
        S_GRANTED = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          invalid_q, invalid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    tries_q, tries_d;
    logic          pin_ok_q, pin_ok_d;
    logic          pin_fail_q, pin_fail_d;
    logic          locked_q, locked_d;
    logic          ok_s, fail_s;
    logic [2:0]    tries_dec_s;

    assign tries_dec_s = (tries_q == 3'd0) ? 3'd0 : (tries_q - 3'd1);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            entry_q    <= '0;
            cnt_q      <= 3'd0;
            invalid_q  <= 1'b0;
            timer_q    <= '0;
            tries_q    <= MAX_TRIES_L;
            pin_ok_q   <= 1'b0;
            pin_fail_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            invalid_q  <= invalid_d;
            timer_q    <= timer_d;
            tries_q    <= tries_d;
            pin_ok_q   <= pin_ok_d;
            pin_fail_q <= pin_fail_d;
            locked_q   <= locked_d;
        end
    end

    // Next-state and datapath update; card removal outranks every other input.
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        invalid_d = invalid_q;
        timer_d   = timer_q;
        tries_d   = tries_q;
        ok_s      = 1'b0;
        fail_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                entry_d   = '0;
                cnt_d     = 3'd0;
                invalid_d = 1'b0;
                timer_d   = '0;
                tries_d   = MAX_TRIES_L;
                if (card_in) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (!card_in) begin
                    state_d   = S_IDLE;
                    entry_d   = '0;
                    cnt_d     = 3'd0;
                    invalid_d = 1'b0;
                    timer_d   = '0;
                    tries_d   = MAX_TRIES_L;
                end else if (cancel) begin
                    entry_d   = '0;
                    cnt_d     = 3'd0;
                    invalid_d = 1'b0;
                    timer_d   = '0;
                end else if (digit_valid) begin
                    entry_d   = (entry_q << 4) | EW'(digit);
                    cnt_d     = cnt_q + 3'd1;
                    invalid_d = invalid_q | (digit > 4'd9);
                    timer_d   = '0;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else if ((timer_q >= TMO) && (cnt_q != 3'd0)) begin
                    // A stalled partial entry costs a try, exactly like a mismatch.
                    fail_s    = 1'b1;
                    tries_d   = tries_dec_s;
                    entry_d   = '0;
                    cnt_d     = 3'd0;
                    invalid_d = 1'b0;
                    timer_d   = '0;
                    state_d   = (tries_dec_s == 3'd0) ? S_LOCKED : S_COLLECT;
                end else if (timer_q < TMO) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            S_CHECK: begin
                if (!card_in) begin
                    state_d   = S_IDLE;
                    entry_d   = '0;
                    cnt_d     = 3'd0;
                    invalid_d = 1'b0;
                    timer_d   = '0;
                    tries_d   = MAX_TRIES_L;
                end else if ((entry_q == stored_pin) && !invalid_q) begin
                    ok_s    = 1'b1;
                    state_d = S_GRANTED;
                end else begin
                    fail_s    = 1'b1;
                    tries_d   = tries_dec_s;
                    entry_d   = '0;
                    cnt_d     = 3'd0;
                    invalid_d = 1'b0;
                    timer_d   = '0;
                    state_d   = (tries_dec_s == 3'd0) ? S_LOCKED : S_COLLECT;
                end
            end
            S_GRANTED: begin
                if (!card_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GRANTED;
                end
            end
            S_LOCKED: begin
                state_d = S_LOCKED;
                tries_d = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register inputs: pulses follow the CHECK/timeout decision by one edge.
    always_comb begin
        pin_ok_d   = ok_s;
        pin_fail_d = fail_s & ~ok_s;
        locked_d   = (state_d == S_LOCKED);
    end

    assign pin_ok     = pin_ok_q;
    assign pin_fail   = pin_fail_q;
    assign locked     = locked_q;
    assign tries_left = tries_q;
    assign digit_cnt  = cnt_q;

endmodule

// File: doc/atm_pin_checker.md
ATM_PIN_CHECKER -- requirements
Module: atm_pin_checker

Interface
REQ-001 SHALL have parameter PIN_DIGITS, default 4, number of BCD digits per PIN entry.
REQ-002 SHALL have parameter MAX_TRIES, default 3, wrong entries allowed before lockout (range 1..7).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, idle cycles allowed between digits.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port card_in, input, 1, level; card present in slot.
REQ-007 SHALL have port digit_valid, input, 1, one-cycle strobe qualifying digit.
REQ-008 SHALL have port digit, input, 4, BCD keypad digit.
REQ-009 SHALL have port cancel, input, 1, one-cycle strobe; abort current entry.
REQ-010 SHALL have port stored_pin, input, 4*PIN_DIGITS, reference PIN; most significant nibble is the first digit; sampled in CHECK.
REQ-011 SHALL have port pin_ok, output, 1, one-cycle pulse; PIN matched.
REQ-012 SHALL have port pin_fail, output, 1, one-cycle pulse; entry rejected (mismatch, invalid digit or timeout).
REQ-013 SHALL have port locked, output, 1, level; card locked out.
REQ-014 SHALL have port tries_left, output, 3, remaining attempts.
REQ-015 SHALL have port digit_cnt, output, 3, digits accepted in current entry.

Function
REQ-016 SHALL implement states IDLE, COLLECT, CHECK, GRANTED, LOCKED.
REQ-017 IDLE: card_in=1 SHALL move to COLLECT next cycle, with digit_cnt=0 and tries_left=MAX_TRIES.
REQ-018 COLLECT: each digit_valid SHALL shift digit into the entry register and increment digit_cnt; inputs without digit_valid SHALL be ignored.
REQ-019 COLLECT: a digit value >9 SHALL be recorded as invalid; the entry still completes and then fails in CHECK.
REQ-020 When the PIN_DIGITS-th digit is accepted, the FSM SHALL enter CHECK on the next edge; digit_valid while in CHECK SHALL be ignored.
REQ-021 CHECK lasts exactly one cycle. On a match with no invalid digit, the FSM SHALL pulse pin_ok in the following cycle and enter GRANTED.
REQ-022 CHECK: otherwise the FSM SHALL pulse pin_fail and decrement tries_left (saturating at 0). If the new value is 0 it SHALL enter LOCKED, else it SHALL return to COLLECT with digit_cnt=0.
REQ-023 COLLECT: a timeout counter SHALL reset on entry to COLLECT and on every accepted digit. When it reaches TIMEOUT_CYC with digit_cnt>0, the block SHALL be treated as a failed entry (same as REQ-022). With digit_cnt=0 the timeout SHALL be ignored.
REQ-024 COLLECT: cancel SHALL clear digit_cnt and the entry register without consuming a try. cancel together with digit_valid in the same cycle: cancel wins and the digit is dropped.
REQ-025 GRANTED: the FSM SHALL stay in GRANTED while card_in=1 and return to IDLE when card_in=0.
REQ-026 LOCKED: locked=1 and the FSM SHALL ignore all inputs except rst. Card removal SHALL NOT clear the lock.
REQ-027 COLLECT or CHECK: card_in=0 SHALL return to IDLE next cycle. No pulse is generated and tries_left SHALL NOT be preserved.
REQ-028 pin_ok and pin_fail SHALL never assert together and SHALL never last more than one cycle.

Reset
REQ-029 rst SHALL force IDLE, pin_ok=0, pin_fail=0, locked=0, tries_left=MAX_TRIES, digit_cnt=0, timeout counter=0, and a cleared entry register. rst has priority over all inputs in every state, including LOCKED.
REQ-030 Reset mid-entry SHALL discard partial digits with no output pulse.

Verification
REQ-031 Match: stored_pin=16'h1234, card_in=1, digits 1,2,3,4 -> pin_ok pulses once, tries_left=3, state GRANTED; card_in=0 -> IDLE.
REQ-032 Lockout: stored_pin=16'h1234, three entries of 1,1,1,1 -> pin_fail pulses three times, tries_left 2,1,0, locked=1. A further correct entry gives no pin_ok; rst clears locked.
REQ-033 Invalid digit: digits 1,2,A,4 -> pin_fail pulses, tries_left=2, digit_cnt=0.
REQ-034 Timeout: digits 1,2 then TIMEOUT_CYC idle cycles -> pin_fail pulses, tries_left=2; with no digits entered, idling gives no pulse.
REQ-035 Cancel: digits 1,2, then cancel asserted together with digit_valid -> digit_cnt=0, tries_left unchanged; digits 1,2,3,4 then give pin_ok.
REQ-036 Card pulled after 2 digits -> IDLE, no pulse; reinserting the card gives tries_left=3.
